if_fetch_stage: RTL

- Instruction-fetch stage and IF/ID pipeline register directly upstream of the main control decoder.
- Owns the PC and drives the instruction-memory request/acknowledge handshake.
- Presents the fetched instruction, with opcode and func pre-split, to the ID stage.
- Handles hazard-unit stalls, branch/jump redirects from EX, and halting on the STOP opcode.

---
 rtl/if_fetch_stage.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, imem handshake, one-entry skid buffer, IF/ID register, STOP halt.
// Optional macro IF_PERF_CNT_EN builds the fetch/stall performance counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  STOP_OPCODE = 6'd63
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [5:0]  ifid_opcode,
  output logic [5:0]  ifid_func,
  output logic [31:0] ifid_pc4,
  output logic        halted,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [31:0] pc_r, pc_nxt_s;
  logic        req_r;
  logic        discard_r, discard_nxt_s;
  logic        halted_r, halted_nxt_s;
  logic        ifid_valid_r, ifid_valid_nxt_s;
  logic [31:0] ifid_instr_r, ifid_instr_nxt_s;
  logic [31:0] ifid_pc4_r, ifid_pc4_nxt_s;
  logic        skid_valid_r, skid_valid_nxt_s;
  logic [31:0] skid_instr_r, skid_instr_nxt_s;
  logic [31:0] skid_pc4_r, skid_pc4_nxt_s;
  logic        ack_s;
  logic        is_stop_s;
  logic [31:0] pc_plus4_s;

  // req_r is high exactly while in FETCH, so an ack outside FETCH is ignored
  assign ack_s      = imem_ack & req_r;
  assign is_stop_s  = (imem_rdata[31:26] == STOP_OPCODE);
  assign pc_plus4_s = pc_r + 32'd4;

  // Next-state, PC, skid and IF/ID update selection
  always_comb begin
    state_nxt_s      = state_r;
    pc_nxt_s         = pc_r;
    discard_nxt_s    = discard_r;
    halted_nxt_s     = halted_r;
    ifid_valid_nxt_s = ifid_valid_r;
    ifid_instr_nxt_s = ifid_instr_r;
    ifid_pc4_nxt_s   = ifid_pc4_r;
    skid_valid_nxt_s = skid_valid_r;
    skid_instr_nxt_s = skid_instr_r;
    skid_pc4_nxt_s   = skid_pc4_r;
    if (redirect) begin
      // an un-acked request still owes us a word that belongs to the wrong path
      state_nxt_s      = ST_FETCH;
      pc_nxt_s         = redirect_pc & 32'hFFFF_FFFC;
      discard_nxt_s    = req_r & ~imem_ack;
      halted_nxt_s     = 1'b0;
      ifid_valid_nxt_s = 1'b0;
      ifid_instr_nxt_s = 32'h0000_0000;
      skid_valid_nxt_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_FETCH;
        end
        ST_FETCH: begin
          if (ack_s && discard_r) begin
            discard_nxt_s = 1'b0;
          end else if (ack_s) begin
            pc_nxt_s     = is_stop_s ? pc_r : pc_plus4_s;
            halted_nxt_s = is_stop_s;
            if (stall) begin
              skid_valid_nxt_s = 1'b1;
              skid_instr_nxt_s = imem_rdata;
              skid_pc4_nxt_s   = pc_plus4_s;
              state_nxt_s      = is_stop_s ? ST_HALT : ST_HOLD;
            end else begin
              ifid_valid_nxt_s = 1'b1;
              ifid_instr_nxt_s = imem_rdata;
              ifid_pc4_nxt_s   = pc_plus4_s;
              state_nxt_s      = is_stop_s ? ST_HALT : ST_FETCH;
            end
          end else if (!stall) begin
            ifid_valid_nxt_s = 1'b0;
            ifid_instr_nxt_s = 32'h0000_0000;
          end else begin
            ifid_valid_nxt_s = ifid_valid_r;
          end
        end
        ST_HOLD, ST_HALT: begin
          if (!stall && skid_valid_r) begin
            ifid_valid_nxt_s = 1'b1;
            ifid_instr_nxt_s = skid_instr_r;
            ifid_pc4_nxt_s   = skid_pc4_r;
            skid_valid_nxt_s = 1'b0;
            state_nxt_s      = (state_r == ST_HOLD) ? ST_FETCH : ST_HALT;
          end else begin
            skid_valid_nxt_s = skid_valid_r;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, PC, skid buffer and IF/ID pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      pc_r         <= RESET_PC;
      req_r        <= 1'b0;
      discard_r    <= 1'b0;
      halted_r     <= 1'b0;
      ifid_valid_r <= 1'b0;
      ifid_instr_r <= 32'h0000_0000;
      ifid_pc4_r   <= 32'h0000_0000;
      skid_valid_r <= 1'b0;
      skid_instr_r <= 32'h0000_0000;
      skid_pc4_r   <= 32'h0000_0000;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      req_r        <= (state_nxt_s == ST_FETCH);
      discard_r    <= discard_nxt_s;
      halted_r     <= halted_nxt_s;
      ifid_valid_r <= ifid_valid_nxt_s;
      ifid_instr_r <= ifid_instr_nxt_s;
      ifid_pc4_r   <= ifid_pc4_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      skid_instr_r <= skid_instr_nxt_s;
      skid_pc4_r   <= skid_pc4_nxt_s;
    end
  end

  assign imem_req    = req_r;
  assign imem_addr   = pc_r;
  assign pc          = pc_r;
  assign ifid_valid  = ifid_valid_r;
  assign ifid_instr  = ifid_instr_r;
  assign ifid_opcode = ifid_instr_r[31:26];
  assign ifid_func   = ifid_instr_r[5:0];
  assign ifid_pc4    = ifid_pc4_r;
  assign halted      = halted_r;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_r;
  logic [31:0] stall_cnt_r;
  logic        load_s;

  // skid is only occupied in HOLD/HALT, so this covers both IF/ID load paths
  assign load_s = ~redirect & ~stall & ((ack_s & ~discard_r) | skid_valid_r);

  // Instructions entering IF/ID and cycles a valid IF/ID entry is held by stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_r <= 32'h0000_0000;
      stall_cnt_r <= 32'h0000_0000;
    end else begin
      fetch_cnt_r <= load_s ? fetch_cnt_r + 32'd1 : fetch_cnt_r;
      stall_cnt_r <= (stall && ifid_valid_r) ? stall_cnt_r + 32'd1 : stall_cnt_r;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_r;
  assign perf_stall_cnt = stall_cnt_r;
`else
  assign perf_fetch_cnt = 32'h0000_0000;
  assign perf_stall_cnt = 32'h0000_0000;
`endif

endmodule
